i2c_write_receiver: RTL and testbench

- I2C slave-side receiver sitting directly downstream of the phase-1 I2C master control unit. It consumes the SCL/SDA lines that unit produces.
- Detects START/STOP, shifts in the address byte and then data bytes, and ACKs by pulling SDA low on an address match.
- Hands each received data byte to the board-side logic with a one-cycle valid pulse.
- Write-only: read requests are NACKed.

---
 rtl/i2c_write_receiver.sv | 182 ++++++++++++++++++
 tb/tb_i2c_write_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_receiver.sv
// Write-only I2C slave receiver: START/STOP detection, address match with ACK, data byte hand-off.
// Optional glitch filter on SCL/SDA enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_write_receiver #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       AddrMatch,
  output logic       Busy,
  output logic       StopSeen
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  logic       scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
  logic       scl_line_s, sda_line_s;
  logic       scl_prev_r, sda_prev_r;
  logic       start_s, stop_s, rise_s, fall_s;
  logic [2:0] state_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] shift_r;
  logic       sda_oe_r;

  // Two-flop synchronizers; reset to the idle-bus level so no false event follows reset
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
    end else begin
      scl_meta_r <= SCL;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= SDA;
      sda_sync_r <= sda_meta_r;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

  logic [3:0] scl_cnt_r, sda_cnt_r;
  logic       scl_filt_r, sda_filt_r;

  // Output follows the input only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      scl_cnt_r  <= 4'd0;
      sda_cnt_r  <= 4'd0;
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
    end else begin
      if (scl_sync_r == scl_filt_r) begin
        scl_cnt_r <= 4'd0;
      end else if (scl_cnt_r == FILT_MAX) begin
        scl_filt_r <= scl_sync_r;
        scl_cnt_r  <= 4'd0;
      end else begin
        scl_cnt_r <= scl_cnt_r + 4'd1;
      end
      if (sda_sync_r == sda_filt_r) begin
        sda_cnt_r <= 4'd0;
      end else if (sda_cnt_r == FILT_MAX) begin
        sda_filt_r <= sda_sync_r;
        sda_cnt_r  <= 4'd0;
      end else begin
        sda_cnt_r <= sda_cnt_r + 4'd1;
      end
    end
  end

  assign scl_line_s = scl_filt_r;
  assign sda_line_s = sda_filt_r;
`else
  assign scl_line_s = scl_sync_r;
  assign sda_line_s = sda_sync_r;
`endif

  // Previous-value stage for edge detection
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_prev_r <= scl_line_s;
      sda_prev_r <= sda_line_s;
    end
  end

  // SDA edges count as START/STOP only while SCL is stable high
  assign start_s = scl_prev_r & scl_line_s & sda_prev_r & ~sda_line_s;
  assign stop_s  = scl_prev_r & scl_line_s & ~sda_prev_r & sda_line_s;
  assign rise_s  = ~scl_prev_r & scl_line_s;
  assign fall_s  = scl_prev_r & ~scl_line_s;

  // Protocol state machine with registered outputs and open-drain enable
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 7'h00;
      sda_oe_r  <= 1'b0;
      RxData    <= 8'h00;
      RxValid   <= 1'b0;
      AddrMatch <= 1'b0;
      Busy      <= 1'b0;
      StopSeen  <= 1'b0;
    end else begin
      RxValid  <= 1'b0;
      StopSeen <= 1'b0;
      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 3'd0;
        shift_r   <= 7'h00;
        sda_oe_r  <= 1'b0;
        AddrMatch <= 1'b0;
        Busy      <= 1'b1;
      end else if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 3'd0;
        sda_oe_r  <= 1'b0;
        AddrMatch <= 1'b0;
        Busy      <= 1'b0;
        StopSeen  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE, ST_IGNORE: begin
            sda_oe_r <= 1'b0;
          end
          ST_ADDR, ST_DATA: begin
            if (rise_s) begin
              shift_r   <= {shift_r[5:0], sda_line_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                // shift_r holds the first seven bits; the live sample is the eighth
                if (state_r == ST_ADDR) begin
                  if ((shift_r == SLAVE_ADDR) && !sda_line_s) begin
                    state_r <= ST_ADDR_ACK;
                  end else begin
                    state_r <= ST_IGNORE;
                  end
                end else begin
                  RxData  <= {shift_r, sda_line_s};
                  RxValid <= 1'b1;
                  state_r <= ST_DATA_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            if (fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else begin
                sda_oe_r  <= 1'b0;
                AddrMatch <= 1'b1;
                state_r   <= ST_DATA;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SDA = sda_oe_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_write_receiver.sv
// Directed bench for i2c_write_receiver: table of bus bytes with expected responses plus corner sequences.
module tb_i2c_write_receiver;

  localparam int FL = 3;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int LAT = 3 + FL;
`else
  localparam int LAT = 3;
`endif
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda_w;
  logic [7:0] rx_data;
  logic       rx_valid, addr_match, busy, stop_seen;

  int n_vec = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int stop_cnt = 0;

  typedef struct {
    logic       st;
    logic [7:0] dat;
    logic       sp;
    logic       ack;
    logic       val;
    logic [7:0] rx;
    logic       match;
  } vec_t;

  vec_t vecs [10];

  pullup (sda_w);
  assign sda_w = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_write_receiver #(.SLAVE_ADDR(7'h48), .FILTER_LEN(FL)) dut (
    .clock    (clk),
    .Reset    (rst_n),
    .SCL      (m_scl),
    .SDA      (sda_w),
    .RxData   (rx_data),
    .RxValid  (rx_valid),
    .AddrMatch(addr_match),
    .Busy     (busy),
    .StopSeen (stop_seen)
  );

  // Count high cycles of the pulse outputs, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (stop_seen === 1'b1) stop_cnt <= stop_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    cyc(Q); m_sda = b;
    cyc(Q); m_scl = 1'b1;
    cyc(Q); s = sda_w;
    cyc(Q); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack, output logic drove);
    logic s;
    drove = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], s);
      if (d[i] && !s) drove = 1'b1;
    end
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic bus_start();
    cyc(Q); m_sda = 1'b1;
    cyc(Q); m_scl = 1'b1;
    cyc(Q); m_sda = 1'b0;
    cyc(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(Q); m_sda = 1'b0;
    cyc(Q); m_scl = 1'b1;
    cyc(Q); m_sda = 1'b1;
    cyc(Q);
  endtask

  initial begin
    logic ack, drove, s;
    int   v0, s0;
    logic [7:0] b;

    vecs[0] = '{1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[2] = '{1'b1, 8'h92, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[4] = '{1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[6] = '{1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
    vecs[9] = '{1'b0, 8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1};

    #12 rst_n = 1'b1;
    cyc(5);
    check("rst_rxdata", rx_data, 8'h00);
    check("rst_rxvalid", rx_valid, 1'b0);
    check("rst_addrmatch", addr_match, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_stopseen", stop_seen, 1'b0);
    check("rst_sda_released", sda_w, 1'b1);
    check("rst_no_stop_pulse", stop_cnt[7:0], 8'd0);

    // START latency: Busy must rise exactly LAT edges after SDA falls
    m_sda = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("start_latency_early", busy, 1'b0);
    @(posedge clk); #1;
    check("start_latency_exact", busy, 1'b1);
    s0 = stop_cnt;
    cyc(Q); m_sda = 1'b1;
    cyc(LAT + 1);
    check("bare_stop_pulse", 8'(stop_cnt - s0), 8'd1);
    check("bare_stop_busy", busy, 1'b0);

    for (int i = 0; i < 10; i++) begin
      v0 = valid_cnt;
      if (vecs[i].st) bus_start();
      send_byte(vecs[i].dat, ack, drove);
      cyc(LAT + 1);
      check($sformatf("v%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("v%0d_no_drive_in_byte", i), drove, 1'b0);
      check($sformatf("v%0d_rxvalid_cycles", i), 8'(valid_cnt - v0), {7'd0, vecs[i].val});
      check($sformatf("v%0d_rxdata", i), rx_data, vecs[i].rx);
      check($sformatf("v%0d_addrmatch", i), addr_match, vecs[i].match);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      if (vecs[i].sp) begin
        s0 = stop_cnt;
        bus_stop();
        cyc(LAT + 1);
        check($sformatf("v%0d_stopseen", i), 8'(stop_cnt - s0), 8'd1);
        check($sformatf("v%0d_busy_after_stop", i), busy, 1'b0);
        check($sformatf("v%0d_match_after_stop", i), addr_match, 1'b0);
      end
    end

    // Repeated START mid-byte discards the partial byte
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h90, ack, drove);
    check("rs_addr_ack", ack, 1'b1);
    send_bit(1'b1, s); send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    bus_start();
    cyc(LAT + 1);
    check("rs_match_cleared", addr_match, 1'b0);
    send_byte(8'h90, ack, drove);
    check("rs_readdr_ack", ack, 1'b1);
    send_byte(8'h5A, ack, drove);
    check("rs_data_ack", ack, 1'b1);
    cyc(LAT + 1);
    check("rs_rxvalid_cycles", 8'(valid_cnt - v0), 8'd1);
    check("rs_rxdata", rx_data, 8'h5A);
    bus_stop();
    cyc(LAT + 1);

    // Reset while the ACK is being held low
    bus_start();
    b = 8'h90;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    cyc(Q); m_sda = 1'b1;
    cyc(Q); m_scl = 1'b1;
    cyc(Q / 2);
    check("ack_held_low", sda_w, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_releases_sda", sda_w, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_addrmatch", addr_match, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(Q / 2); m_scl = 1'b0;
    v0 = valid_cnt;
    send_byte(8'h33, ack, drove);
    cyc(LAT + 1);
    check("post_reset_no_ack", ack, 1'b0);
    check("post_reset_no_rxvalid", 8'(valid_cnt - v0), 8'd0);
    check("post_reset_not_busy", busy, 1'b0);
    bus_stop();
    cyc(LAT + 1);
    v0 = valid_cnt;
    bus_start();
    send_byte(8'h90, ack, drove);
    check("fresh_addr_ack", ack, 1'b1);
    send_byte(8'hC3, ack, drove);
    cyc(LAT + 1);
    check("fresh_rxvalid_cycles", 8'(valid_cnt - v0), 8'd1);
    check("fresh_rxdata", rx_data, 8'hC3);
    bus_stop();
    cyc(LAT + 1);

`ifdef I2C_GLITCH_FILTER_EN
    // Short SDA low pulse with SCL high must not look like START
    m_sda = 1'b0;
    cyc(2);
    m_sda = 1'b1;
    cyc(20);
    check("glitch_no_start", busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
